gbf_fill_arbiter: RTL and testbench

- Services the four GBF refill requests: actv_gbf1/2_need_data and wgt_gbf1/2_need_data from the GBF controller.
- Shares one off-chip read stream (DMA) between the two actv and two wgt global-buffer halves.
- Drives the port-a write side of both gbf_db instances and returns gbf_*_buf*_ready pulses and the *_data_avail flags to the GBF controller.
- Sits between the external DMA and the GBF/PE-array top level.

---
 rtl/gbf_fill_arbiter_pkg.sv | 11 +
 rtl/gbf_fill_arbiter_if.sv | 33 +++
 rtl/gbf_fill_arbiter_rr_arbiter4.sv | 15 +
 rtl/gbf_fill_arbiter.sv | 117 +++++++++++
 tb/tb_gbf_fill_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gbf_fill_arbiter_pkg.sv
// gbf_fill_pkg: shared FSM encoding and requester ids for the GBF refill arbiter
package gbf_fill_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, XFER = 2'd2, DONE = 2'd3} state_t;
  localparam logic [1:0] ID_ACTV1 = 2'd0;
  localparam logic [1:0] ID_ACTV2 = 2'd1;
  localparam logic [1:0] ID_WGT1 = 2'd2;
  localparam logic [1:0] ID_WGT2 = 2'd3;
  function automatic logic [3:0] onehot4(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction
endpackage

// File: rtl/gbf_fill_arbiter_if.sv
// gbf_fill_arbiter_if: refill requests, DMA stream, GBF port-a writes and status
interface gbf_fill_arbiter_if #(parameter int DW = 256, parameter int AW = 5);
  logic actv_gbf1_need_data, actv_gbf2_need_data, wgt_gbf1_need_data, wgt_gbf2_need_data;
  logic fill_req, fill_ack;
  logic [1:0] fill_id;
  logic dma_valid, dma_ready;
  logic [DW-1:0] dma_data;
  logic actv_en1a, actv_we1a, actv_en2a, actv_we2a, wgt_en1a, wgt_we1a, wgt_en2a, wgt_we2a;
  logic [AW-1:0] actv_addr1a, actv_addr2a, wgt_addr1a, wgt_addr2a;
  logic [DW-1:0] actv_w_data1a, actv_w_data2a, wgt_w_data1a, wgt_w_data2a;
  logic gbf_actv_buf1_ready, gbf_actv_buf2_ready, gbf_wgt_buf1_ready, gbf_wgt_buf2_ready;
  logic gbf_actv_data_avail, gbf_wgt_data_avail, busy;
  modport master (
    input actv_gbf1_need_data, actv_gbf2_need_data, wgt_gbf1_need_data, wgt_gbf2_need_data,
    input fill_ack, dma_valid, dma_data,
    output fill_req, fill_id, dma_ready,
    output actv_en1a, actv_we1a, actv_en2a, actv_we2a, wgt_en1a, wgt_we1a, wgt_en2a, wgt_we2a,
    output actv_addr1a, actv_addr2a, wgt_addr1a, wgt_addr2a,
    output actv_w_data1a, actv_w_data2a, wgt_w_data1a, wgt_w_data2a,
    output gbf_actv_buf1_ready, gbf_actv_buf2_ready, gbf_wgt_buf1_ready, gbf_wgt_buf2_ready,
    output gbf_actv_data_avail, gbf_wgt_data_avail, busy
  );
  modport slave (
    output actv_gbf1_need_data, actv_gbf2_need_data, wgt_gbf1_need_data, wgt_gbf2_need_data,
    output fill_ack, dma_valid, dma_data,
    input fill_req, fill_id, dma_ready,
    input actv_en1a, actv_we1a, actv_en2a, actv_we2a, wgt_en1a, wgt_we1a, wgt_en2a, wgt_we2a,
    input actv_addr1a, actv_addr2a, wgt_addr1a, wgt_addr2a,
    input actv_w_data1a, actv_w_data2a, wgt_w_data1a, wgt_w_data2a,
    input gbf_actv_buf1_ready, gbf_actv_buf2_ready, gbf_wgt_buf1_ready, gbf_wgt_buf2_ready,
    input gbf_actv_data_avail, gbf_wgt_data_avail, busy
  );
endinterface

// File: rtl/gbf_fill_arbiter_rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin pick, search starts at ptr_i
module rr_arbiter4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic       grant_valid_o,
  output logic [1:0] grant_id_o
);
  assign grant_valid_o = |req_i;
  // scan farthest offset first so the nearest requester after ptr_i wins
  always_comb begin
    grant_id_o = ptr_i;
    for (int k = 3; k >= 0; k--)
      grant_id_o = req_i[ptr_i + 2'(k)] ? ptr_i + 2'(k) : grant_id_o;
  end
endmodule

// File: rtl/gbf_fill_arbiter.sv
// gbf_fill_arbiter: round-robin refill of the actv/wgt GBF halves from one DMA stream
module gbf_fill_arbiter
  import gbf_fill_pkg::*;
#(
  parameter int GBF_DATA_BITWIDTH = 256,
  parameter int GBF_ADDR_BITWIDTH = 5,
  parameter int GBF_DEPTH = 32,
  parameter int FILL_WORDS = 32
) (
  input logic clk,
  input logic reset,
  gbf_fill_arbiter_if.master bus
);
  localparam int AW = GBF_ADDR_BITWIDTH;
  localparam logic [AW:0] LAST = (AW+1)'((FILL_WORDS > GBF_DEPTH ? GBF_DEPTH : FILL_WORDS) - 1);
  state_t state_q, state_d;
  logic [1:0] rr_q, rr_d, g_q, g_d, gid, avail_q, avail_d;
  logic [3:0] need, need_q, served_q, served_d, req, rdy_q, rdy_d, en_q;
  logic [AW:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q [4];
  logic [GBF_DATA_BITWIDTH-1:0] data_q [4];
  logic gv, acc;
  assign need = {bus.wgt_gbf2_need_data, bus.wgt_gbf1_need_data,
                 bus.actv_gbf2_need_data, bus.actv_gbf1_need_data};
  assign req = need_q & ~served_q;
  assign acc = state_q == XFER && bus.dma_valid;
  rr_arbiter4 u_rr (.req_i(req), .ptr_i(rr_q), .grant_valid_o(gv), .grant_id_o(gid));
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    g_d = g_q;
    cnt_d = cnt_q;
    rdy_d = '0;
    avail_d = avail_q;
    served_d = served_q & need;
    case (state_q)
      IDLE: if (gv) begin
        g_d = gid;
        rr_d = gid + 2'd1;
        state_d = REQ;
      end
      REQ: if (bus.fill_ack) begin
        cnt_d = '0;
        state_d = XFER;
      end
      XFER: if (acc) begin
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == LAST ? DONE : XFER;
      end
      DONE: begin
        rdy_d = onehot4(g_q);
        served_d = served_d | rdy_d;
        avail_d[0] = avail_q[0] | g_q == ID_ACTV1 | g_q == ID_ACTV2;
        avail_d[1] = avail_q[1] | g_q == ID_WGT1 | g_q == ID_WGT2;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q <= '0;
      g_q <= '0;
      cnt_q <= '0;
      need_q <= '0;
      served_q <= '0;
      rdy_q <= '0;
      avail_q <= '0;
      en_q <= '0;
      for (int i = 0; i < 4; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      g_q <= g_d;
      cnt_q <= cnt_d;
      need_q <= need;
      served_q <= served_d;
      rdy_q <= rdy_d;
      avail_q <= avail_d;
      en_q <= acc ? onehot4(g_q) : 4'b0;
      if (acc) begin
        addr_q[g_q] <= cnt_q[AW-1:0];
        data_q[g_q] <= bus.dma_data;
      end
    end
  end
  assign bus.fill_req = state_q == REQ;
  assign bus.fill_id = g_q;
  assign bus.dma_ready = state_q == XFER;
  assign bus.busy = state_q != IDLE;
  assign bus.actv_en1a = en_q[ID_ACTV1];
  assign bus.actv_we1a = en_q[ID_ACTV1];
  assign bus.actv_en2a = en_q[ID_ACTV2];
  assign bus.actv_we2a = en_q[ID_ACTV2];
  assign bus.wgt_en1a = en_q[ID_WGT1];
  assign bus.wgt_we1a = en_q[ID_WGT1];
  assign bus.wgt_en2a = en_q[ID_WGT2];
  assign bus.wgt_we2a = en_q[ID_WGT2];
  assign bus.actv_addr1a = addr_q[ID_ACTV1];
  assign bus.actv_addr2a = addr_q[ID_ACTV2];
  assign bus.wgt_addr1a = addr_q[ID_WGT1];
  assign bus.wgt_addr2a = addr_q[ID_WGT2];
  assign bus.actv_w_data1a = data_q[ID_ACTV1];
  assign bus.actv_w_data2a = data_q[ID_ACTV2];
  assign bus.wgt_w_data1a = data_q[ID_WGT1];
  assign bus.wgt_w_data2a = data_q[ID_WGT2];
  assign bus.gbf_actv_buf1_ready = rdy_q[ID_ACTV1];
  assign bus.gbf_actv_buf2_ready = rdy_q[ID_ACTV2];
  assign bus.gbf_wgt_buf1_ready = rdy_q[ID_WGT1];
  assign bus.gbf_wgt_buf2_ready = rdy_q[ID_WGT2];
  assign bus.gbf_actv_data_avail = avail_q[0];
  assign bus.gbf_wgt_data_avail = avail_q[1];
endmodule

// File: tb/tb_gbf_fill_arbiter.sv
// tb_gbf_fill_arbiter: directed checks of grant order, burst writes, gaps, ack delay and reset
module tb_gbf_fill_arbiter;
  logic clk = 1'b0;
  logic reset;
  int cmp = 0;
  int err = 0;
  logic [3:0] a_need = '0;
  logic [3:0] b_need = '0;
  gbf_fill_arbiter_if #(.DW(256), .AW(5)) a ();
  gbf_fill_arbiter_if #(.DW(256), .AW(5)) b ();
  gbf_fill_arbiter #(.GBF_DATA_BITWIDTH(256), .GBF_ADDR_BITWIDTH(5), .GBF_DEPTH(32), .FILL_WORDS(32))
    dut_a (.clk(clk), .reset(reset), .bus(a));
  gbf_fill_arbiter #(.GBF_DATA_BITWIDTH(256), .GBF_ADDR_BITWIDTH(5), .GBF_DEPTH(32), .FILL_WORDS(4))
    dut_b (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;
  assign {a.wgt_gbf2_need_data, a.wgt_gbf1_need_data, a.actv_gbf2_need_data, a.actv_gbf1_need_data} = a_need;
  assign {b.wgt_gbf2_need_data, b.wgt_gbf1_need_data, b.actv_gbf2_need_data, b.actv_gbf1_need_data} = b_need;
  wire [3:0] a_en = {a.wgt_en2a, a.wgt_en1a, a.actv_en2a, a.actv_en1a};
  wire [3:0] a_we = {a.wgt_we2a, a.wgt_we1a, a.actv_we2a, a.actv_we1a};
  wire [3:0] a_rdy = {a.gbf_wgt_buf2_ready, a.gbf_wgt_buf1_ready, a.gbf_actv_buf2_ready, a.gbf_actv_buf1_ready};
  wire [3:0] b_en = {b.wgt_en2a, b.wgt_en1a, b.actv_en2a, b.actv_en1a};
  wire [3:0] b_rdy = {b.gbf_wgt_buf2_ready, b.gbf_wgt_buf1_ready, b.gbf_actv_buf2_ready, b.gbf_actv_buf1_ready};
  logic [4:0] a_addr [4];
  logic [255:0] a_data [4];
  assign a_addr[0] = a.actv_addr1a;
  assign a_addr[1] = a.actv_addr2a;
  assign a_addr[2] = a.wgt_addr1a;
  assign a_addr[3] = a.wgt_addr2a;
  assign a_data[0] = a.actv_w_data1a;
  assign a_data[1] = a.actv_w_data2a;
  assign a_data[2] = a.wgt_w_data1a;
  assign a_data[3] = a.wgt_w_data2a;
  wire [1023:0] a_bus_data = {a_data[3], a_data[2], a_data[1], a_data[0]};
  wire [41:0] a_ctl = {a.fill_req, a.fill_id, a.dma_ready, a.busy, a_en, a_we, a_rdy,
                       a.gbf_actv_data_avail, a.gbf_wgt_data_avail,
                       a_addr[3], a_addr[2], a_addr[1], a_addr[0]};

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic serve_a(input logic [1:0] id, input logic [7:0] base);
    int t = 0;
    logic [255:0] exp;
    while (!a.fill_req && t < 40) begin
      step();
      t++;
    end
    cmp++;
    if (a.fill_req !== 1'b1 || a.fill_id !== id) begin
      err++;
      $display("FAIL grant: req=%0b id=%0d, want req=1 id=%0d", a.fill_req, a.fill_id, id);
    end
    a.fill_ack = 1'b1;
    step();
    a.fill_ack = 1'b0;
    for (int k = 0; k < 32; k++) begin
      exp = 256'(base) + 256'(k);
      a.dma_valid = 1'b1;
      a.dma_data = exp;
      step();
      cmp++;
      if (a_en !== 4'b1 << id || a_we !== 4'b1 << id || a_addr[id] !== 5'(k) || a_data[id] !== exp) begin
        err++;
        $display("FAIL write id%0d beat%0d: en=%b we=%b addr=%0d data=%0h, want en=we=%b addr=%0d data=%0h",
                 id, k, a_en, a_we, a_addr[id], a_data[id], 4'b1 << id, k, exp);
      end
    end
    a.dma_valid = 1'b0;
    cmp++;
    if (a.dma_ready !== 1'b0 || a.busy !== 1'b1 || a_rdy !== 4'b0) begin
      err++;
      $display("FAIL done id%0d: dma_ready=%b busy=%b rdy=%b, want 0 1 0000", id, a.dma_ready, a.busy, a_rdy);
    end
    step();
    cmp++;
    if (a_rdy !== 4'b1 << id || a_en !== 4'b0) begin
      err++;
      $display("FAIL ready pulse id%0d: rdy=%b en=%b, want rdy=%b en=0000", id, a_rdy, a_en, 4'b1 << id);
    end
    step();
    cmp++;
    if (a_rdy !== 4'b0) begin
      err++;
      $display("FAIL ready width id%0d: rdy=%b, want 0000", id, a_rdy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    cmp++;
    if (a_ctl !== '0 || a_bus_data !== '0 || b.fill_req !== 1'b0 || b.busy !== 1'b0) begin
      err++;
      $display("FAIL reset: ctl=%0h data_nonzero=%b b_req=%b, want all 0", a_ctl, |a_bus_data, b.fill_req);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    a_need = 4'b1000;
    step();
    cmp++;
    if (a.fill_req !== 1'b0) begin
      err++;
      $display("FAIL early fill_req: got %b, want 0", a.fill_req);
    end
    step();
    cmp++;
    if (a.fill_req !== 1'b1 || a.fill_id !== 2'd3) begin
      err++;
      $display("FAIL latency: req=%b id=%0d, want 1 3", a.fill_req, a.fill_id);
    end
    serve_a(2'd3, 8'hA0);
    cmp++;
    if ({a.gbf_actv_data_avail, a.gbf_wgt_data_avail} !== 2'b01) begin
      err++;
      $display("FAIL avail after wgt2: actv=%b wgt=%b, want 0 1", a.gbf_actv_data_avail, a.gbf_wgt_data_avail);
    end
    a_need = '0;
    step();
  endtask

  task automatic test_all_four();
    logic seen = 1'b0;
    reset = 1'b1;
    a_need = 4'hF;
    step();
    reset = 1'b0;
    serve_a(2'd0, 8'h10);
    cmp++;
    if ({a.gbf_actv_data_avail, a.gbf_wgt_data_avail} !== 2'b10) begin
      err++;
      $display("FAIL avail after actv1: actv=%b wgt=%b, want 1 0", a.gbf_actv_data_avail, a.gbf_wgt_data_avail);
    end
    serve_a(2'd1, 8'h20);
    serve_a(2'd2, 8'h30);
    serve_a(2'd3, 8'h40);
    for (int i = 0; i < 10; i++) begin
      seen |= a.fill_req;
      step();
    end
    cmp++;
    if (seen !== 1'b0 || a.busy !== 1'b0) begin
      err++;
      $display("FAIL served mask: regrant=%b busy=%b, want 0 0", seen, a.busy);
    end
  endtask

  task automatic test_rerequest();
    logic seen = 1'b0;
    a_need[0] = 1'b0;
    step();
    a_need[0] = 1'b1;
    serve_a(2'd0, 8'h50);
    for (int i = 0; i < 10; i++) begin
      seen |= a.fill_req;
      step();
    end
    cmp++;
    if (seen !== 1'b0) begin
      err++;
      $display("FAIL held need regrant: fill_req seen=%b, want 0", seen);
    end
    a_need = '0;
    repeat (3) step();
  endtask

  task automatic test_valid_gaps();
    int t = 0;
    int beat = 0;
    logic v;
    b_need = 4'b0010;
    while (!b.fill_req && t < 20) begin
      step();
      t++;
    end
    cmp++;
    if (b.fill_req !== 1'b1 || b.fill_id !== 2'd1) begin
      err++;
      $display("FAIL gap grant: req=%b id=%0d, want 1 1", b.fill_req, b.fill_id);
    end
    b.fill_ack = 1'b1;
    step();
    b.fill_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      v = i % 3 == 0;
      b.dma_valid = v;
      b.dma_data = 256'(8'hC0 + i);
      step();
      cmp++;
      if (v ? (b_en !== 4'b0010 || b.actv_addr2a !== 5'(beat) || b.actv_w_data2a !== 256'(8'hC0 + i)) : b_en !== 4'b0) begin
        err++;
        $display("FAIL gap cycle %0d: en=%b addr=%0d data=%0h, want en=%b addr=%0d", i, b_en, b.actv_addr2a,
                 b.actv_w_data2a, v ? 4'b0010 : 4'b0, beat);
      end
      beat += v ? 1 : 0;
    end
    b.dma_valid = 1'b0;
    cmp++;
    if (b.dma_ready !== 1'b0 || b_rdy !== 4'b0) begin
      err++;
      $display("FAIL gap done: dma_ready=%b rdy=%b, want 0 0000", b.dma_ready, b_rdy);
    end
    step();
    cmp++;
    if (b_rdy !== 4'b0010 || b_en !== 4'b0) begin
      err++;
      $display("FAIL gap ready: rdy=%b en=%b, want 0010 0000", b_rdy, b_en);
    end
    b_need = '0;
    step();
  endtask

  task automatic test_ack_delay();
    int t = 0;
    a_need = 4'b0001;
    while (!a.fill_req && t < 20) begin
      step();
      t++;
    end
    a.dma_valid = 1'b1;
    a.dma_data = 256'hDEAD;
    for (int i = 0; i < 5; i++) begin
      step();
      cmp++;
      if (a.fill_req !== 1'b1 || a.fill_id !== 2'd0 || a_en !== 4'b0 || a.dma_ready !== 1'b0) begin
        err++;
        $display("FAIL ack wait %0d: req=%b id=%0d en=%b dma_ready=%b, want 1 0 0000 0", i, a.fill_req,
                 a.fill_id, a_en, a.dma_ready);
      end
    end
    a.dma_valid = 1'b0;
    serve_a(2'd0, 8'h60);
    a_need = '0;
    repeat (2) step();
  endtask

  task automatic test_reset_mid();
    int t = 0;
    logic seen = 1'b0;
    a_need = 4'b0100;
    while (!a.fill_req && t < 20) begin
      step();
      t++;
    end
    a.fill_ack = 1'b1;
    step();
    a.fill_ack = 1'b0;
    for (int k = 0; k < 10; k++) begin
      a.dma_valid = 1'b1;
      a.dma_data = 256'(8'h70 + k);
      step();
    end
    a.dma_data = 256'h7A;
    reset = 1'b1;
    a_need = 4'b1001;
    #1;
    cmp++;
    if (a_ctl !== '0 || a_bus_data !== '0) begin
      err++;
      $display("FAIL mid-burst reset: ctl=%0h data_nonzero=%b, want all 0", a_ctl, |a_bus_data);
    end
    a.dma_valid = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      seen |= |a_rdy;
      step();
    end
    cmp++;
    if (seen !== 1'b0) begin
      err++;
      $display("FAIL ready after reset: seen=%b, want 0", seen);
    end
    serve_a(2'd0, 8'h80);
    serve_a(2'd3, 8'h90);
    a_need = '0;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    a.fill_ack = 1'b0;
    a.dma_valid = 1'b0;
    a.dma_data = '0;
    b.fill_ack = 1'b0;
    b.dma_valid = 1'b0;
    b.dma_data = '0;
    #2;
    test_reset();
    test_single();
    test_all_four();
    test_rerequest();
    test_valid_gaps();
    test_ack_delay();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
